// File: rtl/if_queue_pkg.sv
// if_queue_pkg: shared constants and types for the IF/ID instruction queue.
//   N_DEF     default width of PC and instruction words
//   DEPTH_DEF default queue depth (power of two, >= 2)
//   PTR_W     read/write pointer width for the default depth
//   CNT_W     occupancy counter width (must represent DEPTH itself)
//   entry_t   one queued {PC+4, instruction} pair at the default width
// Optional feature macro used by the queue: IFQ_BYPASS_EN.
package if_queue_pkg;

    localparam int N_DEF     = 32;
    localparam int DEPTH_DEF = 4;
    localparam int PTR_W     = $clog2(DEPTH_DEF);
    localparam int CNT_W     = PTR_W + 1;

    typedef struct packed {
        logic [N_DEF-1:0] pc;
        logic [N_DEF-1:0] instr;
    } entry_t;

endpackage

// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch/decode side signals of the IF/ID queue.
//   master : driven by the pipeline (fetch push, decode pop, branch flush)
//   slave  : the queue itself (full flag, head entry, occupancy)
interface if_id_queue_if #(
    parameter int N     = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          pushIn;
    logic [N-1:0]  PCIn;
    logic [N-1:0]  instructionIn;
    logic          fullOut;
    logic          popIn;
    logic          flushIn;
    logic          validOut;
    logic [N-1:0]  PCOut;
    logic [N-1:0]  instructionOut;
    logic [CW-1:0] countOut;

    modport master (
        output pushIn, PCIn, instructionIn, popIn, flushIn,
        input  fullOut, validOut, PCOut, instructionOut, countOut
    );

    modport slave (
        input  pushIn, PCIn, instructionIn, popIn, flushIn,
        output fullOut, validOut, PCOut, instructionOut, countOut
    );
endinterface

// File: rtl/if_queue_mem.sv
// if_queue_mem: queue storage. One synchronous write port, one
// asynchronous read port. Contents are zeroed on reset only.
//   clk, rst       clock, async active-low reset
//   we/waddr/wdata write port
//   raddr/rdata    combinational read port
module if_queue_mem #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mem_q <= '0;
        else      mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry circular buffer of {PC+4, instruction} between
// fetch and decode. fullOut freezes fetch; the head entry feeds decode.
// A taken branch (flushIn) empties the queue at the next edge.
//   clk, rst : pipeline clock, async active-low reset
//   q        : slave side of if_id_queue_if (push/pop/flush in,
//              full/valid/head/count out)
// Macro IFQ_BYPASS_EN: when empty, a pushed entry appears on the head
// outputs in the same cycle; if also popped it is never written.
module if_id_queue
    import if_queue_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic           clk,
    input logic           rst,
    if_id_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           empty, full, byp, wr_en, rd_adv;
    logic [2*N-1:0] head;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));

`ifdef IFQ_BYPASS_EN
    assign byp = empty & q.pushIn & ~q.flushIn;
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        // A bypassed entry consumed in the same cycle never touches storage.
        wr_en    = q.pushIn & ~full & ~q.flushIn & ~(byp & q.popIn);
        rd_adv   = q.popIn & ~empty & ~q.flushIn;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (q.flushIn) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by overflow.
            if (wr_en)  wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_adv) rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + CW'(wr_en) - CW'(rd_adv);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    if_queue_mem #(.W(2*N), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata ({q.PCIn, q.instructionIn}),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    // Storage at rd_ptr may hold a stale popped entry, so mask it when empty.
    always_comb begin
        if (byp)        {q.PCOut, q.instructionOut} = {q.PCIn, q.instructionIn};
        else if (empty) {q.PCOut, q.instructionOut} = '0;
        else            {q.PCOut, q.instructionOut} = head;
    end

    assign q.validOut = ~empty | byp;
    assign q.fullOut  = full;
    assign q.countOut = cnt_q;
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: self-checking bench for if_id_queue (N=32, DEPTH=4).
// Table-driven directed vectors, hand-written corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_if_id_queue;
    import if_queue_pkg::*;

    localparam int N = 32;
    localparam int D = 4;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    if_id_queue_if #(.N(N), .DEPTH(D)) bus();
    if_id_queue #(.N(N), .DEPTH(D)) dut (.clk(clk), .rst(rst), .q(bus));

    always #5 clk = ~clk;

    int nchk  = 0;
    int npass = 0;
    entry_t model[$];

    typedef struct {
        bit          push, pop, flush;
        logic [31:0] pc;
        bit          ev;
        logic [31:0] epc;
        int          ecnt;
        bit          ef;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic idle();
        bus.pushIn = 0; bus.popIn = 0; bus.flushIn = 0;
        bus.PCIn = '0; bus.instructionIn = '0;
    endtask

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return 32'hE000_0000 | pc;
    endfunction

    task automatic drive(input bit push, input bit pop, input bit flush,
                         input logic [31:0] pc, input logic [31:0] instr);
        @(negedge clk);
        bus.pushIn = push; bus.popIn = pop; bus.flushIn = flush;
        bus.PCIn = pc; bus.instructionIn = instr;
        #1;
    endtask

    // Head outputs expected before the edge, including the bypass path.
    task automatic check_comb(input string tag);
        entry_t h;
        bit v;
        if (model.size() > 0) begin v = 1; h = model[0]; end
        else if (BYP && bus.pushIn && !bus.flushIn) begin
            v = 1; h.pc = bus.PCIn; h.instr = bus.instructionIn;
        end else begin v = 0; h = '0; end
        chk({tag, " comb valid"}, 32'(bus.validOut), 32'(v));
        chk({tag, " comb pc"},    bus.PCOut, h.pc);
        chk({tag, " comb instr"}, bus.instructionOut, h.instr);
    endtask

    // Reference next state from the queue rules.
    task automatic model_edge();
        entry_t e;
        bit full_now, empty_now;
        full_now  = (model.size() == D);
        empty_now = (model.size() == 0);
        e.pc = bus.PCIn; e.instr = bus.instructionIn;
        if (bus.flushIn) model.delete();
        else if (!(BYP && empty_now && bus.pushIn && bus.popIn)) begin
            if (bus.popIn && !empty_now) void'(model.pop_front());
            if (bus.pushIn && !full_now) model.push_back(e);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic check_state(input string tag);
        entry_t h;
        h = (model.size() > 0) ? model[0] : '0;
        chk({tag, " valid"}, 32'(bus.validOut), 32'(model.size() > 0));
        chk({tag, " pc"},    bus.PCOut, h.pc);
        chk({tag, " instr"}, bus.instructionOut, h.instr);
        chk({tag, " count"}, 32'(bus.countOut), 32'(model.size()));
        chk({tag, " full"},  32'(bus.fullOut), 32'(model.size() == D));
    endtask

    task automatic step(input string tag, input bit push, input bit pop, input bit flush,
                        input logic [31:0] pc, input logic [31:0] instr);
        drive(push, pop, flush, pc, instr);
        check_comb(tag);
        tick();
        check_state(tag);
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst = 0;
        model.delete();
        #2;
        rst = 1;
    endtask

    initial begin
        idle();
        #1;
        chk("reset valid", 32'(bus.validOut), 32'd0);
        chk("reset full",  32'(bus.fullOut), 32'd0);
        chk("reset count", 32'(bus.countOut), 32'd0);
        chk("reset pc",    bus.PCOut, 32'd0);
        @(negedge clk);
        rst = 1;

        // Directed table: fill, ignored push when full, full push+pop, flush.
        tbl[0] = '{1, 0, 0, 32'd4,     1, 32'd4,     1, 0};
        tbl[1] = '{1, 0, 0, 32'd8,     1, 32'd4,     2, 0};
        tbl[2] = '{1, 0, 0, 32'd12,    1, 32'd4,     3, 0};
        tbl[3] = '{1, 0, 0, 32'd16,    1, 32'd4,     4, 1};
        tbl[4] = '{1, 0, 0, 32'd20,    1, 32'd4,     4, 1};
        tbl[5] = '{1, 1, 0, 32'd20,    1, 32'd8,     3, 0};
        tbl[6] = '{1, 1, 1, 32'd24,    0, 32'd0,     0, 0};
        tbl[7] = '{1, 0, 0, 32'h100,   1, 32'h100,   1, 0};
        tbl[8] = '{0, 1, 0, 32'd0,     0, 32'd0,     0, 0};
        tbl[9] = '{0, 1, 0, 32'd0,     0, 32'd0,     0, 0};
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].push, tbl[i].pop, tbl[i].flush, tbl[i].pc, mk_instr(tbl[i].pc));
            tick();
            chk($sformatf("tbl%0d valid", i), 32'(bus.validOut), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d pc", i), bus.PCOut, tbl[i].epc);
            chk($sformatf("tbl%0d instr", i), bus.instructionOut,
                tbl[i].ev ? mk_instr(tbl[i].epc) : 32'd0);
            chk($sformatf("tbl%0d count", i), 32'(bus.countOut), 32'(tbl[i].ecnt));
            chk($sformatf("tbl%0d full", i), 32'(bus.fullOut), 32'(tbl[i].ef));
        end

        // Fill then drain in order.
        do_reset();
        for (int i = 1; i <= 4; i++) step("fill", 1, 0, 0, 32'(4*i), mk_instr(32'(4*i)));
        chk("fill full", 32'(bus.fullOut), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("drain order", bus.PCOut, 32'(4*i));
            step("drain", 0, 1, 0, 32'd0, 32'd0);
        end

        // Continuous push+pop across pointer wrap.
        do_reset();
        step("wrap", 1, 0, 0, 32'd4, mk_instr(32'd4));
        for (int k = 2; k <= 10; k++) begin
            step("wrap", 1, 1, 0, 32'(4*k), mk_instr(32'(4*k)));
            chk("wrap steady count", 32'(bus.countOut), 32'd1);
            chk("wrap head", bus.PCOut, 32'(4*k));
        end
        step("wrap end", 0, 1, 0, 32'd0, 32'd0);

        // Asynchronous reset between edges.
        do_reset();
        step("prerst", 1, 0, 0, 32'd4, mk_instr(32'd4));
        step("prerst", 1, 0, 0, 32'd8, mk_instr(32'd8));
        #2;
        rst = 0;
        model.delete();
        #1;
        chk("midrst valid", 32'(bus.validOut), 32'd0);
        chk("midrst count", 32'(bus.countOut), 32'd0);
        chk("midrst pc",    bus.PCOut, 32'd0);
        chk("midrst instr", bus.instructionOut, 32'd0);
        @(negedge clk);
        rst = 1;

        // Empty queue, push and pop together: bypass vs one-cycle latency.
        drive(1, 1, 0, 32'h200, 32'hE3A0_1005);
        chk("byp valid", 32'(bus.validOut), 32'(BYP));
        chk("byp instr", bus.instructionOut, BYP ? 32'hE3A0_1005 : 32'd0);
        tick();
        check_state("byp after");
        chk("byp count", 32'(bus.countOut), BYP ? 32'd0 : 32'd1);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            pc = $urandom & 32'hFFFF_FFFC;
            step("rand", ($urandom % 10) < 7, ($urandom % 10) < 5,
                 ($urandom % 25) == 0, pc, $urandom);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage and the decode stage of the 5-stage ARM pipeline. It buffers up to DEPTH fetched {PC+4, instruction} pairs so fetch can keep running while decode is held by a hazard. A taken branch flushes it. It replaces a single-entry IF/ID register: its full flag drives the fetch freeze, and its head entry feeds ID.

## Interface
- N, 32, data width of PC and instruction
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- pushIn  in  1  fetch presents a valid instruction this cycle
- PCIn  in  N  PC+4 from fetch
- instructionIn  in  N  fetched instruction word
- fullOut  out  1  queue holds DEPTH entries; drives fetch freeze
- popIn  in  1  decode consumes the head entry this cycle (deasserted on hazard)
- flushIn  in  1  branch taken; discard all entries
- validOut  out  1  head entry is valid
- PCOut  out  N  head PC+4
- instructionOut  out  N  head instruction
- countOut  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Circular buffer with read pointer, write pointer and occupancy count. Pointers wrap modulo DEPTH.
- Occupancy state is derived from the count:
  - EMPTY: count = 0
  - PARTIAL: 0 < count < DEPTH
  - FULL: count = DEPTH
- Push is accepted when pushIn=1, fullOut=0 and flushIn=0. The entry is written at the write pointer, which then increments.
- Push while full is ignored, even if popIn=1 in the same cycle. Fetch is frozen by fullOut and will re-present the instruction.
- Pop is accepted when popIn=1 and validOut=1. The read pointer increments. popIn while empty has no effect.
- Simultaneous accepted push and pop in PARTIAL: count unchanged, both pointers advance.
- flushIn=1 has priority over everything. Next edge: pointers = 0, count = 0. Any push and pop in that cycle are discarded.
- When empty (and no bypass), validOut=0 and PCOut/instructionOut = 0.
- Head outputs are read combinationally from the entry at the read pointer.
- fullOut = (count == DEPTH) and validOut = (count ≠ 0), both decoded from registered state.

## Timing
- Reset (rst=0, asynchronous): pointers, count and all storage go to 0. validOut=0, fullOut=0, countOut=0, PCOut=0, instructionOut=0.
- Release of rst is synchronous to clk.
- Push-to-head latency: 1 cycle. Data pushed at edge k is visible on the outputs after edge k if the queue was empty.
- fullOut rises in the cycle after the DEPTH-th accepted push. It falls in the cycle after the first pop from FULL.
- Flush takes effect at the next edge. validOut=0 from that edge onward until a new push is accepted.
- Reset mid-operation discards all contents immediately, without waiting for an edge.

## Configuration
- IFQ_BYPASS_EN defined: when count=0, pushIn=1 and flushIn=0, validOut=1 and PCOut/instructionOut = PCIn/instructionIn combinationally.
  - If popIn=1 in the same cycle, the entry is consumed and not written; count stays 0.
  - If popIn=0, the entry is written normally.
- IFQ_BYPASS_EN undefined: no combinational path from inputs to outputs; latency is always 1 cycle.

## Structure
- Shared package if_queue_pkg holds:
  - DEPTH default
  - PTR_W = $clog2(DEPTH)
  - CNT_W = PTR_W+1
  - entry typedef {pc[N-1:0], instr[N-1:0]}
- Sub-module if_queue_mem holds the register array: one synchronous write port and one asynchronous read port, with no reset on data beyond zeroing. The top level owns pointers, count and control.

## Test plan
- Reset mid-stream: push 2 entries, assert rst=0 between edges → validOut=0, countOut=0 and outputs 0 immediately.
- Fill: push PCIn=4,8,12,16 with popIn=0 → fullOut=1 after the 4th edge, countOut=4. A 5th push (PCIn=20) is ignored. Popping 4 times yields 4,8,12,16 in order.
- Wrap-around: continuous push and pop of 10 entries (PCIn=4…40) → countOut holds steady, outputs in order, pointers wrap with no loss.
- Full with simultaneous push/pop: at count=4, pushIn=1 with PCIn=20 and popIn=1 → head advances, count=3, PCIn=20 is not stored.
- Flush: count=3, flushIn=1 with pushIn=1 and popIn=1 → next cycle count=0, validOut=0. A following push of PCIn=0x100 appears at the head.
- Bypass (IFQ_BYPASS_EN): empty queue, pushIn=1 with instructionIn=0xE3A01005 and popIn=1 → same-cycle validOut=1 and instructionOut=0xE3A01005, count stays 0. With the macro undefined, validOut stays 0 until the next edge.
